// File: rtl/fetch_sequencer.sv
// Fetch control FSM: drives PC stall/halt/branch and the I-mem request,
// inserting fixed flush bubbles after taken branches.
module fetch_sequencer #(
    parameter int DATAW        = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNTW         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DATAW-1:0] pc,
    input  logic             imem_ready,
    input  logic             hazard_stall,
    input  logic             halt_req,
    input  logic             ex_branch_taken,
    input  logic [DATAW-1:0] ex_branch_target,
    output logic             pc_stall,
    output logic             pc_halt,
    output logic             pc_branch,
    output logic [DATAW-1:0] pc_branch_target,
    output logic             imem_req,
    output logic [DATAW-1:0] imem_addr,
    output logic             fetch_valid,
    output logic             flush,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNTW-1:0]  fetch_count
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FETCH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;
    localparam logic [1:0] S_HALTED   = 2'd3;

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    // flush_cnt holds the number of REDIRECT cycles still to spend, including the current one.
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [1:0] AFTER_BRANCH = (FLUSH_CYCLES > 1) ? S_REDIRECT : S_FETCH;

    logic [1:0]    state, state_next;
    logic [FW-1:0] flush_cnt, flush_cnt_next;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_next     = state;
        flush_cnt_next = flush_cnt;
        pc_stall       = 1'b0;
        pc_halt        = 1'b0;
        pc_branch      = 1'b0;
        imem_req       = 1'b0;
        fetch_valid    = 1'b0;
        flush          = 1'b0;
        halted         = 1'b0;
        case (state)
            S_IDLE: begin
                pc_stall = 1'b1;
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (ex_branch_taken) begin
                    pc_branch      = 1'b1;
                    flush          = 1'b1;
                    flush_cnt_next = FLUSH_LOAD;
                    state_next     = AFTER_BRANCH;
                end else if (halt_req) begin
                    pc_halt    = 1'b1;
                    pc_stall   = 1'b1;
                    state_next = S_HALTED;
                end else begin
                    pc_stall    = hazard_stall | ~imem_ready;
                    fetch_valid = imem_ready & ~hazard_stall;
                end
            end
            S_REDIRECT: begin
                flush    = 1'b1;
                pc_stall = 1'b1;
                if (ex_branch_taken) begin
                    pc_branch      = 1'b1;
                    flush_cnt_next = FLUSH_LOAD;
                    state_next     = AFTER_BRANCH;
                end else if (flush_cnt <= FW'(1)) begin
                    flush_cnt_next = '0;
                    state_next     = S_FETCH;
                end else begin
                    flush_cnt_next = flush_cnt - FW'(1);
                end
            end
            default: begin
                pc_halt  = 1'b1;
                pc_stall = 1'b1;
                halted   = 1'b1;
            end
        endcase
    end

    assign pc_branch_target = pc_branch ? {ex_branch_target[DATAW-1:2], 2'b00} : '0;
    assign imem_addr        = pc;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            state        <= S_IDLE;
            flush_cnt    <= '0;
            fetch_count  <= '0;
            misalign_err <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            if (fetch_valid) fetch_count <= fetch_count + CNTW'(1);
            if (pc_branch && (ex_branch_target[1:0] != 2'b00)) misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle model checks every output each
// cycle, and literal checks pin the documented scenarios.
module tb_fetch_sequencer;

    localparam int DATAW = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNTW = 32;

    logic clk = 1'b0;
    logic rst, start, imem_ready, hazard_stall, halt_req, ex_branch_taken;
    logic [DATAW-1:0] pc, ex_branch_target;
    logic pc_stall, pc_halt, pc_branch, imem_req, fetch_valid, flush, halted, misalign_err;
    logic [DATAW-1:0] pc_branch_target, imem_addr;
    logic [CNTW-1:0] fetch_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.DATAW(DATAW), .FLUSH_CYCLES(FLUSH_CYCLES), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .imem_ready(imem_ready),
        .hazard_stall(hazard_stall), .halt_req(halt_req), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .pc_stall(pc_stall), .pc_halt(pc_halt),
        .pc_branch(pc_branch), .pc_branch_target(pc_branch_target), .imem_req(imem_req),
        .imem_addr(imem_addr), .fetch_valid(fetch_valid), .flush(flush), .halted(halted),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    // Program counter the sequencer controls: branch wins, else hold on stall, else +4.
    always @(posedge clk) begin
        if (rst) pc <= '0;
        else if (pc_branch) pc <= pc_branch_target;
        else if (!pc_stall) pc <= pc + 32'd4;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: idle / halted flags, count of remaining bubble cycles.
    bit m_valid = 1'b0;
    bit m_idle = 1'b1, m_halted = 1'b0, m_mis = 1'b0;
    int m_bubbles = 0;
    longint m_count = 0;

    initial begin
        bit e_stall, e_halt, e_branch, e_req, e_valid, e_flush, e_hlt;
        bit n_idle, n_halted, n_mis;
        int n_bubbles;
        longint n_count;
        logic [DATAW-1:0] e_tgt;
        forever begin
            @(negedge clk);
            e_stall = 0; e_halt = 0; e_branch = 0; e_req = 0;
            e_valid = 0; e_flush = 0; e_hlt = 0;
            if (m_idle) e_stall = 1;
            else if (m_halted) begin e_stall = 1; e_halt = 1; e_hlt = 1; end
            else if (m_bubbles > 0) begin e_stall = 1; e_flush = 1; e_branch = ex_branch_taken; end
            else begin
                e_req = 1;
                if (ex_branch_taken) begin e_branch = 1; e_flush = 1; end
                else if (halt_req) begin e_halt = 1; e_stall = 1; end
                else begin
                    e_stall = hazard_stall | ~imem_ready;
                    e_valid = imem_ready & ~hazard_stall;
                end
            end
            e_tgt = e_branch ? (ex_branch_target & ~32'd3) : 32'd0;
            if (m_valid) begin
                if (!(e_branch && !m_idle && m_bubbles == 0)) check("model pc_stall", 64'(pc_stall), 64'(e_stall));
                check("model pc_halt", 64'(pc_halt), 64'(e_halt));
                check("model pc_branch", 64'(pc_branch), 64'(e_branch));
                check("model pc_branch_target", 64'(pc_branch_target), 64'(e_tgt));
                check("model imem_req", 64'(imem_req), 64'(e_req));
                check("model imem_addr", 64'(imem_addr), 64'(pc));
                check("model fetch_valid", 64'(fetch_valid), 64'(e_valid));
                check("model flush", 64'(flush), 64'(e_flush));
                check("model halted", 64'(halted), 64'(e_hlt));
                check("model misalign_err", 64'(misalign_err), 64'(m_mis));
                check("model fetch_count", 64'(fetch_count), 64'(m_count[CNTW-1:0]));
            end
            n_idle = m_idle; n_halted = m_halted; n_mis = m_mis;
            n_bubbles = m_bubbles; n_count = m_count;
            if (rst) begin
                n_idle = 1; n_halted = 0; n_mis = 0; n_bubbles = 0; n_count = 0;
            end else begin
                if (e_valid) n_count++;
                if (e_branch && ex_branch_target[1:0] != 2'b00) n_mis = 1;
                if (m_idle) begin
                    if (start) n_idle = 0;
                end else if (!m_halted) begin
                    if (ex_branch_taken) n_bubbles = FLUSH_CYCLES - 1;
                    else if (m_bubbles > 0) n_bubbles = m_bubbles - 1;
                    else if (halt_req) n_halted = 1;
                end
            end
            @(posedge clk);
            if (rst) m_valid = 1'b1;
            m_idle = n_idle; m_halted = n_halted; m_mis = n_mis;
            m_bubbles = n_bubbles; m_count = n_count;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; start = 0; imem_ready = 0; hazard_stall = 0; halt_req = 0;
        ex_branch_taken = 0; ex_branch_target = '0;
        tick();
        rst = 0;
        check("reset pc_stall", 64'(pc_stall), 64'd1);
        check("reset imem_req", 64'(imem_req), 64'd0);
        check("reset fetch_count", 64'(fetch_count), 64'd0);

        // Start and fetch five sequential instructions.
        start = 1; imem_ready = 1;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) tick();
        imem_ready = 0;
        #1;
        check("seq fetch_count", 64'(fetch_count), 64'd5);
        check("seq pc", 64'(pc), 64'd20);

        // I-mem not ready for three cycles.
        for (int i = 0; i < 3; i++) begin
            check("wait pc_stall", 64'(pc_stall), 64'd1);
            check("wait imem_req", 64'(imem_req), 64'd1);
            tick();
        end
        imem_ready = 1;
        #1;
        check("wait release fetch_valid", 64'(fetch_valid), 64'd1);
        tick();
        check("wait fetch_count", 64'(fetch_count), 64'd6);

        // Taken branch to 0x100.
        ex_branch_taken = 1; ex_branch_target = 32'h100;
        #1;
        check("br pc_branch", 64'(pc_branch), 64'd1);
        check("br flush", 64'(flush), 64'd1);
        check("br target", 64'(pc_branch_target), 64'h100);
        tick();
        ex_branch_taken = 0;
        #1;
        check("br bubble flush", 64'(flush), 64'd1);
        check("br bubble imem_req", 64'(imem_req), 64'd0);
        tick();
        check("br resume flush", 64'(flush), 64'd0);
        check("br resume imem_addr", 64'(imem_addr), 64'h100);
        check("br resume fetch_valid", 64'(fetch_valid), 64'd1);

        // Branch and halt together: branch wins; misaligned target is cleaned.
        ex_branch_taken = 1; halt_req = 1; ex_branch_target = 32'h102;
        #1;
        check("race target", 64'(pc_branch_target), 64'h100);
        check("race pc_halt", 64'(pc_halt), 64'd0);
        tick();
        ex_branch_taken = 0;
        #1;
        check("race misalign_err", 64'(misalign_err), 64'd1);
        check("race halted", 64'(halted), 64'd0);
        tick();
        halt_req = 0;
        #1;
        check("redirect ignores halt", 64'(halted), 64'd0);
        check("redirect resume addr", 64'(imem_addr), 64'h100);

        // Hazard stall freezes the fetch.
        hazard_stall = 1;
        #1;
        check("hazard pc_stall", 64'(pc_stall), 64'd1);
        check("hazard fetch_valid", 64'(fetch_valid), 64'd0);
        tick();
        hazard_stall = 0;

        // Back-to-back branches: second reloads the bubble count.
        ex_branch_taken = 1; ex_branch_target = 32'h40;
        tick();
        ex_branch_target = 32'h80;
        #1;
        check("rebranch pc_branch", 64'(pc_branch), 64'd1);
        tick();
        ex_branch_taken = 0;
        #1;
        check("rebranch still flushing", 64'(flush), 64'd1);
        tick();
        check("rebranch resume addr", 64'(imem_addr), 64'h80);
        check("rebranch resume flush", 64'(flush), 64'd0);

        // Halt, then everything but reset is ignored.
        halt_req = 1;
        tick();
        halt_req = 0;
        check("halt halted", 64'(halted), 64'd1);
        check("halt pc_halt", 64'(pc_halt), 64'd1);
        start = 1; ex_branch_taken = 1; ex_branch_target = 32'h300;
        tick();
        tick();
        check("halt sticky", 64'(halted), 64'd1);
        check("halt no branch", 64'(pc_branch), 64'd0);
        start = 0; ex_branch_taken = 0;
        rst = 1;
        tick();
        rst = 0;
        check("halt reset halted", 64'(halted), 64'd0);
        check("halt reset count", 64'(fetch_count), 64'd0);
        check("halt reset misalign", 64'(misalign_err), 64'd0);
        check("halt reset pc_stall", 64'(pc_stall), 64'd1);

        // Reset in the middle of a redirect, after setting misalign_err.
        start = 1;
        tick();
        start = 0;
        ex_branch_taken = 1; ex_branch_target = 32'h203;
        tick();
        ex_branch_taken = 0;
        check("mid misalign set", 64'(misalign_err), 64'd1);
        check("mid in redirect", 64'(flush), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        check("mid reset flush", 64'(flush), 64'd0);
        check("mid reset pc_stall", 64'(pc_stall), 64'd1);
        check("mid reset misalign", 64'(misalign_err), 64'd0);
        check("mid reset imem_req", 64'(imem_req), 64'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
